mem_router: RTL

//  Parametrised N-way memory-port router between one LSU-side master and NSLV slave ports.
//  - Decodes each request address against per-slave base/size windows and rebases the address.
//  - Tracks outstanding reads in an in-order ID FIFO, so read data returns from the right slave.
//  - Answers unmapped reads itself with an error response.
//  - Replaces the fixed two-way memory/UART split.

---
 rtl/mem_router.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_router.sv
// N-way memory-port router: decodes master requests onto per-slave address windows and
// steers read responses back in order through an ID FIFO; unmapped reads get an error reply.
module mem_router #(
  parameter int                   NSLV     = 2,
  parameter int                   AW       = 32,
  parameter int                   DW       = 32,
  parameter int                   DEPTH    = 4,
  parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h30000000, 32'h00000000},
  parameter logic [NSLV*AW-1:0]   SLV_SIZE = {32'h00001000, 32'h30000000},
  parameter logic [DW-1:0]        ERR_DATA = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic                   m_write_en,
  input  logic [DW/8-1:0]        m_byte_en,
  input  logic [AW-1:0]          m_addr,
  input  logic [DW-1:0]          m_wdata,
  output logic                   m_rvalid,
  output logic [DW-1:0]          m_rdata,
  output logic                   m_rerr,
  output logic [NSLV-1:0]        s_valid,
  input  logic [NSLV-1:0]        s_ready,
  output logic [NSLV-1:0]        s_write_en,
  output logic [NSLV*DW/8-1:0]   s_byte_en,
  output logic [NSLV*AW-1:0]     s_addr,
  output logic [NSLV*DW-1:0]     s_wdata,
  input  logic [NSLV*DW-1:0]     s_rdata,
  input  logic [NSLV-1:0]        s_rvalid,
  output logic                   decode_err,
  output logic                   order_err
);

  localparam int IW = $clog2(NSLV + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] ERR_ID = IW'(NSLV);

  // Window test done one bit wider so base+size near the top of the space cannot wrap.
  function automatic logic win_hit(input logic [AW-1:0] addr,
                                   input logic [AW-1:0] base,
                                   input logic [AW-1:0] size);
    logic [AW:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return ({1'b0, addr} >= {1'b0, base}) && (off < {1'b0, size});
  endfunction

  logic [IW-1:0] tgt;
  logic          mapped;
  logic          tgt_ready;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          ord_hit;
  logic [IW-1:0] head_id;

  logic [IW-1:0] id_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = id_mem[rd_ptr];

  // Decode: scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    tgt = ERR_ID;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (win_hit(m_addr, SLV_BASE[i*AW +: AW], SLV_SIZE[i*AW +: AW]))
        tgt = IW'(i);
    end
  end

  assign mapped = (tgt != ERR_ID);

  always_comb begin
    tgt_ready = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (tgt == IW'(i))
        tgt_ready = s_ready[i];
    end
  end

  always_comb begin
    m_ready = 1'b0;
    if (m_valid) begin
      if (m_write_en)
        m_ready = mapped ? tgt_ready : 1'b1;
      else
        m_ready = mapped ? (tgt_ready && !full) : !full;
    end
  end

  // Only reads need a FIFO slot, so writes are presented to the slave even while full.
  always_comb begin
    s_valid    = '0;
    s_addr     = '0;
    s_write_en = {NSLV{m_write_en}};
    s_byte_en  = {NSLV{m_byte_en}};
    s_wdata    = {NSLV{m_wdata}};
    for (int i = 0; i < NSLV; i++) begin
      s_valid[i]         = m_valid && (tgt == IW'(i)) && (m_write_en || !full);
      s_addr[i*AW +: AW] = m_addr - SLV_BASE[i*AW +: AW];
    end
  end

  assign push = m_valid && m_ready && !m_write_en;

  // Response steering: the FIFO head decides which slave may answer this cycle.
  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rerr   = 1'b0;
    ord_hit  = 1'b0;
    if (!empty && head_id == ERR_ID) begin
      m_rvalid = 1'b1;
      m_rdata  = ERR_DATA;
      m_rerr   = 1'b1;
    end
    for (int i = 0; i < NSLV; i++) begin
      if (!empty && head_id == IW'(i)) begin
        m_rvalid = s_rvalid[i];
        m_rdata  = s_rdata[i*DW +: DW];
      end
      if (s_rvalid[i] && (empty || head_id != IW'(i)))
        ord_hit = 1'b1;
    end
  end

  assign pop = m_rvalid;

  always_ff @(posedge clk) begin
    if (push)
      id_mem[wr_ptr] <= tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      decode_err <= 1'b0;
      order_err  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (m_valid && m_write_en && !mapped)
        decode_err <= 1'b1;
      if (ord_hit)
        order_err <= 1'b1;
    end
  end

endmodule
